decoder_rr_arbiter: RTL and testbench
=====================================

Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares one decoded resource among 8 requesters.
- Registers a binary grant index and drives the matching one-hot enable line, the same output form as the 3-to-8 decoder.
- Sequences grants through a small state machine with release, timeout and a one-cycle dead gap between owners.
- Sits in front of the shared decoder/enable fabric so only one downstream unit is enabled at a time.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 for this revision.
- IDXW, 3, width of grant index, log2(NREQ).
- MAX_HOLD, 16, maximum grant length in cycles. 0 disables the timeout.
- CNTW, 5, width of hold counter; must hold MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global arbiter enable. Low forces release and blocks new grants.
- req  input  NREQ  request lines, level, one per requester.
- done  input  1  owner releases the resource. Sampled only in GRANT.
- gnt_valid  output  1  a grant is active.
- gnt_idx  output  IDXW  binary index of current/last winner.
- gnt_onehot  output  NREQ  decoded enable, 1<<gnt_idx when gnt_valid, else all zero.
- timeout  output  1  one-cycle pulse when a grant is revoked by hold expiry.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, timeout=0, busy=0.
  - Round-robin pointer ptr=0; hold counter=0.
- All outputs are registered; no combinational path from req/done to outputs.
- Arbitration function: the winner is the first set bit of req scanning ptr, ptr+1, ... wrapping modulo 8.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and req!=0: go to GRANT; load gnt_idx=winner, gnt_onehot=1<<winner, gnt_valid=1, counter=0.
  - Otherwise stay.
  - Latency: req high at edge k gives grant outputs valid after edge k, visible in cycle k+1.
- GRANT: the hold counter increments every cycle. Exit to GAP on the first edge where any of these holds:
  - done=1
  - req[gnt_idx]=0 (requester withdrew)
  - en=0
  - MAX_HOLD!=0 and counter==MAX_HOLD-1
- On exit from GRANT:
  - gnt_valid=0, gnt_onehot=0.
  - gnt_idx retains the winner.
  - ptr=(gnt_idx+1) mod 8, with 3-bit natural wrap (7 goes to 0).
- timeout pulses for exactly one cycle, the first GAP cycle, only when hold expiry was the sole exit cause.
  - If done, withdrawal or en=0 coincides with expiry, timeout stays 0.
- GAP: exactly one dead cycle, all enables zero. Then arbitrate as in IDLE:
  - requests present and en=1: go to GRANT with the new winner;
  - otherwise go to IDLE.
- Back-to-back owners are therefore separated by exactly one cycle with gnt_onehot=0.
- gnt_onehot is never multi-hot. It is zero whenever gnt_valid=0.
- done outside GRANT is ignored.
- Changes to non-granted req bits during GRANT have no effect until the next arbitration.
- A single requester held high is re-granted after each GAP (ptr wraps back to it).
- Reset mid-GRANT: outputs clear immediately and asynchronously; ptr returns to 0. The first post-reset grant favours the lowest index.
- busy=1 in GRANT and GAP.

Test Plan:
- Reset, then req=8'b0000_0100, en=1 -> grant one cycle later: gnt_idx=2, gnt_onehot=8'h04, busy=1. Pulse done -> next cycle gnt_onehot=0; following cycle regrant idx 2.
- req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0. Exactly one zero-enable cycle between consecutive grants; gnt_onehot never multi-hot.
- MAX_HOLD=4, req=8'h01 held, done=0 -> gnt_valid high exactly 4 cycles, then timeout=1 for one cycle with gnt_onehot=0, then regrant idx 0. Same run with done asserted on cycle 4 -> timeout stays 0.
- Grant idx 5 active, drop req[5] -> release next edge, ptr=6. With req=8'h41 pending, the next winner is 6, not 0.
- Grant active, drive en=0 -> release next edge; stays IDLE with req=8'hFF until en=1, then grants from ptr.
- Grant idx 3 active, assert rst_n=0 mid-cycle -> gnt_valid, gnt_onehot, gnt_idx drop to 0 without waiting for clk. After release with req=8'h88 -> winner idx 3.

Source files
------------

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface decoder_rr_arbiter_if #(
  parameter int NREQ = 8,
  parameter int IDXW = 3
);
  logic            en;
  logic [NREQ-1:0] req;
  logic            done;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt_onehot;
  logic            timeout;
  logic            busy;

  modport master (
    output en, req, done,
    input  gnt_valid, gnt_idx, gnt_onehot, timeout, busy
  );

  modport slave (
    input  en, req, done,
    output gnt_valid, gnt_idx, gnt_onehot, timeout, busy
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters with registered binary and one-hot grant,
// release/timeout handling and a one-cycle dead gap between owners.
module decoder_rr_arbiter #(
  parameter int NREQ     = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNTW     = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  decoder_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] ptr, ptr_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic            valid_q, valid_nx;
  logic [IDXW-1:0] idx_q, idx_nx;
  logic [NREQ-1:0] onehot_q, onehot_nx;
  logic            timeout_q, timeout_nx;

  logic [IDXW-1:0] winner, cand;
  logic            found;
  logic            any_req;
  logic            expire;
  logic            release_other;

  // Scan ptr, ptr+1, ... with natural IDXW-bit wrap; first set request wins.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr + IDXW'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign any_req       = |bus.req;
  assign expire        = (MAX_HOLD != 0) && (cnt == CNTW'(MAX_HOLD - 1));
  assign release_other = bus.done || !bus.req[idx_q] || !bus.en;

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    cnt_nx     = cnt;
    valid_nx   = valid_q;
    idx_nx     = idx_q;
    onehot_nx  = onehot_q;
    timeout_nx = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (bus.en && any_req) begin
          state_nx  = GRANT;
          idx_nx    = winner;
          valid_nx  = 1'b1;
          onehot_nx = NREQ'(1) << winner;
          cnt_nx    = '0;
        end else begin
          state_nx  = IDLE;
          valid_nx  = 1'b0;
          onehot_nx = '0;
        end
      end
      GRANT: begin
        cnt_nx = cnt + 1'b1;
        if (release_other || expire) begin
          state_nx   = GAP;
          valid_nx   = 1'b0;
          onehot_nx  = '0;
          ptr_nx     = idx_q + 1'b1;
          timeout_nx = expire && !release_other;
        end
      end
      default: begin
        state_nx  = IDLE;
        valid_nx  = 1'b0;
        onehot_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      onehot_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      cnt       <= cnt_nx;
      valid_q   <= valid_nx;
      idx_q     <= idx_nx;
      onehot_q  <= onehot_nx;
      timeout_q <= timeout_nx;
    end
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench: two arbiters (hold limits 16 and 4) share one stimulus
// stream and are compared each cycle against a cycle-count reference model.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_rr_arbiter_if #(.NREQ(8), .IDXW(3)) bus16 ();
  decoder_rr_arbiter_if #(.NREQ(8), .IDXW(3)) bus4 ();

  assign bus16.en   = en;
  assign bus16.req  = req;
  assign bus16.done = done;
  assign bus4.en    = en;
  assign bus4.req   = req;
  assign bus4.done  = done;

  decoder_rr_arbiter #(.NREQ(8), .IDXW(3), .MAX_HOLD(16), .CNTW(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );
  decoder_rr_arbiter #(.NREQ(8), .IDXW(3), .MAX_HOLD(4), .CNTW(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  // Reference model state, index 0 = hold 16, index 1 = hold 4.
  bit m_valid[2];
  bit m_gap[2];
  bit m_to[2];
  int m_idx[2];
  int m_ptr[2];
  int m_held[2];
  int hold_lim[2] = '{16, 4};

  function automatic int pick(int p, logic [7:0] r);
    for (int i = 0; i < 8; i++)
      if (r[(p + i) % 8]) return (p + i) % 8;
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_gap[k] = 0; m_to[k] = 0;
      m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    bit rel, expired;
    if (m_valid[k]) begin
      m_held[k]++;
      rel     = done || !req[m_idx[k]] || !en;
      expired = (hold_lim[k] != 0) && (m_held[k] == hold_lim[k]);
      m_to[k] = 0;
      if (rel || expired) begin
        m_valid[k] = 0;
        m_gap[k]   = 1;
        m_ptr[k]   = (m_idx[k] + 1) % 8;
        m_to[k]    = expired && !rel;
      end
    end else begin
      m_to[k]  = 0;
      m_gap[k] = 0;
      if (en && req != 8'h00) begin
        m_idx[k]   = pick(m_ptr[k], req);
        m_valid[k] = 1;
        m_held[k]  = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(int k, logic v, logic [2:0] idx, logic [7:0] oh, logic to, logic bz);
    string s;
    logic [7:0] exp_oh;
    s = (k == 0) ? "h16" : "h4";
    exp_oh = m_valid[k] ? (8'h01 << m_idx[k]) : 8'h00;
    check({s, ".gnt_valid"}, 32'(v), 32'(m_valid[k]));
    check({s, ".gnt_idx"}, 32'(idx), 32'(m_idx[k]));
    check({s, ".gnt_onehot"}, 32'(oh), 32'(exp_oh));
    check({s, ".timeout"}, 32'(to), 32'(m_to[k]));
    check({s, ".busy"}, 32'(bz), 32'(m_valid[k] || m_gap[k]));
    check({s, ".onehot0"}, 32'($onehot0(oh)), 32'd1);
  endtask

  task automatic check_all();
    check_dut(0, bus16.gnt_valid, bus16.gnt_idx, bus16.gnt_onehot, bus16.timeout, bus16.busy);
    check_dut(1, bus4.gnt_valid, bus4.gnt_idx, bus4.gnt_onehot, bus4.timeout, bus4.busy);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check_all();
  endtask

  // Called at a negedge: assert reset mid-cycle, confirm outputs clear with no clock edge.
  task automatic mid_cycle_reset();
    #2 rst_n = 1'b0;
    #1;
    check("async.gnt_valid", 32'(bus16.gnt_valid), 32'd0);
    check("async.gnt_onehot", 32'(bus16.gnt_onehot), 32'd0);
    check("async.gnt_idx", 32'(bus16.gnt_idx), 32'd0);
    check("async.busy", 32'(bus4.busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int  exp_next, gap_len, to_cnt, run_len;
  bit  prev_valid;

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Single requester, release by done, re-grant after the gap.
    en = 1'b1; req = 8'b0000_0100;
    tick();
    check("p1.idx", 32'(bus16.gnt_idx), 32'd2);
    check("p1.onehot", 32'(bus16.gnt_onehot), 32'h04);
    check("p1.busy", 32'(bus16.busy), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("p1.gap_onehot", 32'(bus16.gnt_onehot), 32'h00);
    tick();
    check("p1.regrant", 32'({bus16.gnt_valid, bus16.gnt_idx}), 32'({1'b1, 3'd2}));

    // All requesting, done every grant cycle: rotation with exactly one dead cycle.
    req = 8'hFF; exp_next = 3; gap_len = 0; prev_valid = 1;
    for (int c = 0; c < 40; c++) begin
      done = m_valid[0];
      tick();
      if (bus16.gnt_valid && !prev_valid) begin
        check("rot.idx", 32'(bus16.gnt_idx), 32'(exp_next));
        check("rot.gap_len", 32'(gap_len), 32'd1);
        exp_next = (exp_next + 1) % 8;
      end
      gap_len    = bus16.gnt_valid ? 0 : gap_len + 1;
      prev_valid = bus16.gnt_valid;
    end
    done = 1'b0;

    // Hold expiry on the 4-cycle instance.
    req = 8'h01; to_cnt = 0; run_len = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (bus4.timeout) begin
        to_cnt++;
        check("to.run_len", 32'(run_len), 32'd4);
        check("to.onehot", 32'(bus4.gnt_onehot), 32'h00);
      end
      run_len = bus4.gnt_valid ? run_len + 1 : 0;
    end
    check("to.seen", 32'(to_cnt > 0), 32'd1);

    // done coinciding with expiry suppresses the pulse.
    to_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      done = m_valid[1] && (m_held[1] == 3);
      tick();
      if (bus4.timeout) to_cnt++;
    end
    done = 1'b0;
    check("to.suppressed", 32'(to_cnt), 32'd0);

    // Withdrawal of the owner advances ptr past it.
    en = 1'b0; req = '0;
    repeat (2) tick();
    mid_cycle_reset();
    en = 1'b1; req = 8'h20;
    tick();
    check("wd.idx5", 32'(bus16.gnt_idx), 32'd5);
    tick();
    req = 8'h41;
    tick();
    check("wd.released", 32'(bus16.gnt_valid), 32'd0);
    tick();
    check("wd.next6", 32'(bus16.gnt_idx), 32'd6);

    // en low releases and blocks grants; re-enable grants from ptr.
    en = 1'b0; req = 8'hFF;
    repeat (4) tick();
    check("en.idle", 32'(bus16.busy), 32'd0);
    en = 1'b1;
    tick();
    check("en.from_ptr", 32'(bus16.gnt_idx), 32'd7);

    // Reset mid-grant, then lowest index is favoured.
    en = 1'b0;
    repeat (2) tick();
    mid_cycle_reset();
    en = 1'b1; req = 8'h08;
    tick();
    check("rst.idx3", 32'(bus16.gnt_idx), 32'd3);
    tick();
    mid_cycle_reset();
    req = 8'h88;
    tick();
    check("rst.winner", 32'({bus16.gnt_valid, bus16.gnt_idx}), 32'({1'b1, 3'd3}));

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      en   = ($urandom_range(0, 15) != 0);
      done = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
